// File: rtl/io_dcc_gray_ctrl_if.sv
// Control and status bundle between the DCC controller and its environment.
interface io_dcc_gray_ctrl_if;
    logic       dcc_en;
    logic       duty_hi;
    logic [3:0] r_gray;
    logic [3:0] f_gray;
    logic       dcc_lock;
    logic       dcc_sat;
    logic       dcc_busy;

    modport master (
        output dcc_en, duty_hi,
        input  r_gray, f_gray, dcc_lock, dcc_sat, dcc_busy
    );

    modport slave (
        input  dcc_en, duty_hi,
        output r_gray, f_gray, dcc_lock, dcc_sat, dcc_busy
    );
endinterface

// File: rtl/io_dcc_gray_ctrl.sv
// Duty-cycle-correction loop: integrates the comparator over a window and
// steps the rise or fall delay code of the DCC line by one per window.
//
// state   | meaning
// IDLE    | loop disabled, codes held
// SETTLE  | waiting for the delay line to settle after a code change
// MEASURE | counting comparator ones over one window
// UPDATE  | one-cycle decision and code step
module io_dcc_gray_ctrl #(
    parameter int WIN_LOG2   = 6,
    parameter int SETTLE_CYC = 8,
    parameter int HYST       = 2,
    parameter int LOCK_REV   = 4
) (
    input  logic              clk,
    input  logic              reset,
    io_dcc_gray_ctrl_if.slave dcc
);
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int HALF     = 1 << (WIN_LOG2 - 1);
    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LOCK_W   = $clog2(LOCK_REV + 1);

    localparam logic [WIN_LOG2:0]   HI_TH    = (WIN_LOG2 + 1)'(HALF + HYST);
    localparam logic [WIN_LOG2:0]   LO_TH    = (WIN_LOG2 + 1)'(HALF - HYST);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [WIN_LOG2-1:0] SAMP_LD   = WIN_LOG2'(WIN - 1);
    localparam logic [LOCK_W-1:0]   LOCK_MAX  = LOCK_W'(LOCK_REV);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_SHORT, DIR_LONG} dir_t;

    state_t              state;
    dir_t                dir;
    dir_t                step;
    logic [3:0]          r_bin, f_bin, r_nxt, f_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [WIN_LOG2-1:0] samp_cnt;
    logic [WIN_LOG2:0]   ones_cnt;
    logic [LOCK_W-1:0]   lock_cnt, lock_nxt;
    logic                win_hi, win_lo, sat_win;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    assign dcc.dcc_busy = (state != IDLE);

    // Window decision: which code moves, saturation, and the next lock count.
    always_comb begin
        win_hi   = (ones_cnt > HI_TH);
        win_lo   = (ones_cnt < LO_TH);
        r_nxt    = r_bin;
        f_nxt    = f_bin;
        sat_win  = 1'b0;
        step     = DIR_NONE;
        lock_nxt = lock_cnt;
        if (win_hi) begin
            if (f_bin != 4'd0) begin
                f_nxt = f_bin - 4'd1;
                step  = DIR_SHORT;
            end else if (r_bin != 4'd15) begin
                r_nxt = r_bin + 4'd1;
                step  = DIR_SHORT;
            end else begin
                sat_win = 1'b1;
            end
        end else if (win_lo) begin
            if (r_bin != 4'd0) begin
                r_nxt = r_bin - 4'd1;
                step  = DIR_LONG;
            end else if (f_bin != 4'd15) begin
                f_nxt = f_bin + 4'd1;
                step  = DIR_LONG;
            end else begin
                sat_win = 1'b1;
            end
        end
        // A first step after enable has no previous direction: neither event.
        if (sat_win || (step != DIR_NONE && step == dir)) begin
            lock_nxt = '0;
        end else if ((!win_hi && !win_lo) ||
                     (step != DIR_NONE && dir != DIR_NONE && step != dir)) begin
            lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
        end
    end

    // Sequencer with registered code, lock and saturation outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dir          <= DIR_NONE;
            r_bin        <= 4'd0;
            f_bin        <= 4'd0;
            settle_cnt   <= '0;
            samp_cnt     <= '0;
            ones_cnt     <= '0;
            lock_cnt     <= '0;
            dcc.r_gray   <= 4'd0;
            dcc.f_gray   <= 4'd0;
            dcc.dcc_lock <= 1'b0;
            dcc.dcc_sat  <= 1'b0;
        end else if (!dcc.dcc_en) begin
            state        <= IDLE;
            dir          <= DIR_NONE;
            settle_cnt   <= '0;
            samp_cnt     <= '0;
            ones_cnt     <= '0;
            lock_cnt     <= '0;
            dcc.dcc_lock <= 1'b0;
            dcc.dcc_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    settle_cnt <= SETTLE_LD;
                    ones_cnt   <= '0;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state    <= MEASURE;
                        samp_cnt <= SAMP_LD;
                        ones_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                MEASURE: begin
                    ones_cnt <= ones_cnt + {{WIN_LOG2{1'b0}}, dcc.duty_hi};
                    if (samp_cnt == '0) begin
                        state <= UPDATE;
                    end else begin
                        samp_cnt <= samp_cnt - 1'b1;
                    end
                end
                UPDATE: begin
                    r_bin        <= r_nxt;
                    f_bin        <= f_nxt;
                    dcc.r_gray   <= to_gray(r_nxt);
                    dcc.f_gray   <= to_gray(f_nxt);
                    dcc.dcc_sat  <= sat_win;
                    lock_cnt     <= lock_nxt;
                    dcc.dcc_lock <= (lock_nxt >= LOCK_MAX);
                    if (step != DIR_NONE) begin
                        dir <= step;
                    end
                    state      <= SETTLE;
                    settle_cnt <= SETTLE_LD;
                    ones_cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
